// File: rtl/drygascon_round_if.sv
// -----------------------------------------------------------------------------
// drygascon_round_if
// Handshake and datapath-control bundle between the DryGASCON input/output
// FSMs (master side) and the round controller (slave side).
//
// Signals
//   start/start_rdy          job request / controller ready
//   init_mode, mix_en, clr_r job configuration, sampled on accept
//   din_valid                MixSx data chunk available
//   do_mix, sel_c            datapath input and cc source selects
//   mix_rnd, gascon_rnd      MixSx chunk index / GASCON round constant index
//   ena_c, ena_r, rst_r      cc load, rr accumulate load, rr clear
//   busy, done               job in progress / one-cycle completion pulse
//   abort, aborted           cancel request / one-cycle cancel pulse
//                            (present only with DRYGASCON_ABORT_EN defined)
// -----------------------------------------------------------------------------
interface drygascon_round_if #(
  parameter int RND_W = 4
);
  logic             start;
  logic             start_rdy;
  logic             init_mode;
  logic             mix_en;
  logic             clr_r;
  logic             din_valid;
  logic             do_mix;
  logic [RND_W-1:0] mix_rnd;
  logic [RND_W-1:0] gascon_rnd;
  logic             ena_c;
  logic             sel_c;
  logic             ena_r;
  logic             rst_r;
  logic             busy;
  logic             done;
`ifdef DRYGASCON_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (
    output start, init_mode, mix_en, clr_r, din_valid, abort,
    input  start_rdy, do_mix, mix_rnd, gascon_rnd, ena_c, sel_c, ena_r,
           rst_r, busy, done, aborted
  );
  modport slave (
    input  start, init_mode, mix_en, clr_r, din_valid, abort,
    output start_rdy, do_mix, mix_rnd, gascon_rnd, ena_c, sel_c, ena_r,
           rst_r, busy, done, aborted
  );
`else
  modport master (
    output start, init_mode, mix_en, clr_r, din_valid,
    input  start_rdy, do_mix, mix_rnd, gascon_rnd, ena_c, sel_c, ena_r,
           rst_r, busy, done
  );
  modport slave (
    input  start, init_mode, mix_en, clr_r, din_valid,
    output start_rdy, do_mix, mix_rnd, gascon_rnd, ena_c, sel_c, ena_r,
           rst_r, busy, done
  );
`endif
endinterface

// File: rtl/drygascon_round_ctrl.sv
// -----------------------------------------------------------------------------
// drygascon_round_ctrl
// Sequences one DryGASCON permutation job: an optional MixSx phase
// (MIX_ROUNDS data chunks, stalled by din_valid) followed by GASCON_ROUNDS
// or INIT_ROUNDS GASCON rounds, then a one-cycle DONE.
//
// Ports
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   drygascon_round_if.slave (handshake, config, datapath enables)
//
// Build option
//   DRYGASCON_ABORT_EN  adds bus.abort / bus.aborted; abort in MIX or GASCON
//                       returns to IDLE without a done pulse.
//
// state  | meaning
// IDLE   | ready for a job, start_rdy=1
// MIX    | MixSx absorb, one chunk per din_valid cycle
// GASCON | GASCON rounds, cc and rr loaded every cycle
// DONE   | one-cycle done pulse, not ready
// -----------------------------------------------------------------------------
module drygascon_round_ctrl #(
  parameter int MIX_ROUNDS    = 14,
  parameter int GASCON_ROUNDS = 8,
  parameter int INIT_ROUNDS   = 12,
  parameter int RND_W         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  drygascon_round_if.slave        bus
);

  typedef enum logic [1:0] {S_IDLE, S_MIX, S_GASCON, S_DONE} state_t;

  localparam logic [RND_W-1:0] MIX_LAST  = RND_W'(MIX_ROUNDS - 1);
  localparam logic [RND_W-1:0] GAS_LAST  = RND_W'(GASCON_ROUNDS - 1);
  localparam logic [RND_W-1:0] INIT_LAST = RND_W'(INIT_ROUNDS - 1);

  state_t           state, state_nx;
  logic [RND_W-1:0] cnt, cnt_nx;
  logic             init_q, init_nx;
  logic             accept;
  logic             abort_hit;
  logic [RND_W-1:0] gas_last;

`ifdef DRYGASCON_ABORT_EN
  // Only meaningful while a phase is running; IDLE/DONE ignore it below.
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign accept   = bus.start && (state == S_IDLE) && !rst;
  assign gas_last = init_q ? INIT_LAST : GAS_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      init_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      init_q <= init_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    init_nx  = init_q;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          init_nx  = bus.init_mode;
          cnt_nx   = '0;
          state_nx = bus.mix_en ? S_MIX : S_GASCON;
        end
      end
      S_MIX: begin
        // abort wins over the last-chunk transition
        if (abort_hit) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else if (bus.din_valid) begin
          if (cnt == MIX_LAST) begin
            cnt_nx   = '0;
            state_nx = S_GASCON;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_GASCON: begin
        if (abort_hit) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else if (cnt == gas_last) begin
          cnt_nx   = '0;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.start_rdy  = 1'b0;
    bus.do_mix     = 1'b0;
    bus.sel_c      = 1'b0;
    bus.mix_rnd    = '0;
    bus.gascon_rnd = '0;
    bus.ena_c      = 1'b0;
    bus.ena_r      = 1'b0;
    bus.rst_r      = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
`ifdef DRYGASCON_ABORT_EN
    bus.aborted    = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        bus.start_rdy = 1'b1;
        bus.rst_r     = accept && bus.clr_r;
      end
      S_MIX: begin
        bus.do_mix  = 1'b1;
        bus.sel_c   = 1'b1;
        bus.busy    = 1'b1;
        bus.mix_rnd = cnt;
        bus.ena_c   = bus.din_valid && !abort_hit;
`ifdef DRYGASCON_ABORT_EN
        bus.aborted = abort_hit;
`endif
      end
      S_GASCON: begin
        bus.busy       = 1'b1;
        bus.gascon_rnd = cnt;
        bus.ena_c      = !abort_hit;
        bus.ena_r      = !abort_hit;
`ifdef DRYGASCON_ABORT_EN
        bus.aborted    = abort_hit;
`endif
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_drygascon_round_ctrl.sv
module tb_drygascon_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drygascon_round_if #(.RND_W(4)) bus();

  drygascon_round_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // per-cycle din_valid pattern, index = cycles after accept
  bit dv [0:511];

  // observations of the last job
  int r_lat, r_ena_c, r_ena_r, r_rdy_bad, r_enac_bad, r_timeout;
  int r_int_hit, r_int_out, r_int_en, r_post_done, r_post_rdy, r_post_busy;
  int r_done_rdy, r_rst_r_acc, r_after_ab;
  logic [15:0] r_after;
  int obs_mix[$];
  int obs_gas[$];
  int obs_stall[$];

  localparam logic [15:0] IDLE_OUTS = 16'h8000;

  function automatic logic [15:0] outs();
    return {bus.start_rdy, bus.do_mix, bus.sel_c, bus.ena_c, bus.ena_r,
            bus.rst_r, bus.busy, bus.done, bus.mix_rnd, bus.gascon_rnd};
  endfunction

  // Reference: a job takes the accept cycle, enough MIX cycles to see 14
  // valid chunks, N GASCON rounds, and lands on done.
  function automatic int model_lat(input bit mix, input bit init, output int stalls);
    int n, got, c;
    n = init ? 12 : 8;
    got = 0;
    c = 1;
    stalls = 0;
    if (mix) begin
      while (got < 14) begin
        if (dv[c]) got++;
        else stalls++;
        c++;
      end
    end
    return 1 + (mix ? 14 + stalls : 0) + n;
  endfunction

  task automatic fill_dv(input int mode);
    for (int i = 0; i < 512; i++)
      dv[i] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  // kind: 0 none, 1 rst when gascon_rnd==at, 2 abort when mix_rnd==at
  task automatic run_job(input bit mix, input bit init, input bit clr,
                         input bit hold, input int kind, input int at);
    bit fin;
    int c;
    obs_mix.delete(); obs_gas.delete(); obs_stall.delete();
    r_lat = -1; r_ena_c = 0; r_ena_r = 0; r_rdy_bad = 0; r_enac_bad = 0;
    r_timeout = 0; r_int_hit = 0; r_int_out = 0; r_int_en = 0; r_after = '1;
    r_post_done = 0; r_post_rdy = 0; r_post_busy = 0; r_done_rdy = 1;
    r_rst_r_acc = -1; r_after_ab = 0;
    @(negedge clk);
    bus.start = 1'b0;
    c = 0;
    #1;
    while (bus.start_rdy !== 1'b1 && c < 300) begin
      @(negedge clk); #1; c++;
    end
    if (bus.start_rdy !== 1'b1) begin r_timeout = 1; return; end
    bus.start = 1'b1; bus.mix_en = mix; bus.init_mode = init; bus.clr_r = clr;
    bus.din_valid = dv[0];
    #1;
    r_rst_r_acc = int'(bus.rst_r);
    fin = 0;
    for (c = 1; c <= 300 && !fin; c++) begin
      @(negedge clk);
      bus.start     = hold ? 1'b1 : 1'($urandom_range(0, 1));
      bus.init_mode = 1'($urandom_range(0, 1));
      bus.mix_en    = 1'($urandom_range(0, 1));
      bus.clr_r     = 1'($urandom_range(0, 1));
      bus.din_valid = dv[c];
      #1;
      if (kind == 1 && bus.ena_r === 1'b1 && int'(bus.gascon_rnd) == at) begin
        rst = 1'b1; r_int_hit = 1; fin = 1;
      end
`ifdef DRYGASCON_ABORT_EN
      else if (kind == 2 && bus.do_mix === 1'b1 && int'(bus.mix_rnd) == at) begin
        bus.abort = 1'b1;
        #1;
        r_int_out = int'(bus.aborted);
        r_int_en  = int'(bus.ena_c | bus.ena_r);
        r_int_hit = 1; fin = 1;
      end
`endif
      else begin
        if (bus.do_mix === 1'b1 && bus.ena_c === 1'b1) obs_mix.push_back(int'(bus.mix_rnd));
        if (bus.do_mix === 1'b1 && !bus.din_valid) obs_stall.push_back(int'(bus.mix_rnd));
        if (bus.do_mix === 1'b1 && bus.ena_c !== bus.din_valid) r_enac_bad++;
        if (bus.ena_r === 1'b1) obs_gas.push_back(int'(bus.gascon_rnd));
        if (bus.ena_c === 1'b1) r_ena_c++;
        if (bus.ena_r === 1'b1) r_ena_r++;
        if (bus.start_rdy !== 1'b0) r_rdy_bad++;
        if (bus.done === 1'b1) begin r_lat = c; r_done_rdy = int'(bus.start_rdy); fin = 1; end
      end
    end
    if (!fin) begin r_timeout = 1; return; end
    if (r_int_hit != 0) begin
      @(negedge clk);
      rst = 1'b0; bus.start = 1'b0;
`ifdef DRYGASCON_ABORT_EN
      bus.abort = 1'b0;
`endif
      #1;
      r_after = outs();
`ifdef DRYGASCON_ABORT_EN
      r_after_ab = int'(bus.aborted);
`endif
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); #1;
        if (bus.done === 1'b1) r_post_done++;
      end
      return;
    end
    @(negedge clk);
    bus.start = hold;
    #1;
    r_post_rdy  = int'(bus.start_rdy);
    r_post_done = int'(bus.done);
    if (hold) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      r_post_busy = int'(bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (outs() !== IDLE_OUTS) begin
      failures++; $display("FAIL reset_outs: got %h, required %h", outs(), IDLE_OUTS);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== IDLE_OUTS) begin
      failures++; $display("FAIL idle_after_reset: got %h, required %h", outs(), IDLE_OUTS);
    end
  endtask

  task automatic test_mix_normal();
    bit ok;
    fill_dv(0);
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    checks++;
    if (r_timeout != 0) begin failures++; $display("FAIL t1_timeout: got %0d, required 0", r_timeout); end
    checks++;
    if (r_lat != 23) begin failures++; $display("FAIL t1_latency: got %0d, required 23", r_lat); end
    checks++;
    if (r_ena_r != 8) begin failures++; $display("FAIL t1_ena_r_cycles: got %0d, required 8", r_ena_r); end
    ok = (obs_mix.size() == 14);
    foreach (obs_mix[i]) if (obs_mix[i] != i) ok = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL t1_mix_seq: got %0d entries, required 0..13", obs_mix.size()); end
    ok = (obs_gas.size() == 8);
    foreach (obs_gas[i]) if (obs_gas[i] != i) ok = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL t1_gascon_seq: got %0d entries, required 0..7", obs_gas.size()); end
    checks++;
    if (r_rst_r_acc != 0) begin failures++; $display("FAIL t1_rst_r: got %0d, required 0", r_rst_r_acc); end
  endtask

  task automatic test_init_clr();
    bit ok;
    fill_dv(1);
    run_job(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    checks++;
    if (r_rst_r_acc != 1) begin failures++; $display("FAIL t2_rst_r: got %0d, required 1", r_rst_r_acc); end
    checks++;
    if (r_lat != 13) begin failures++; $display("FAIL t2_latency: got %0d, required 13", r_lat); end
    ok = (obs_gas.size() == 12) && (obs_mix.size() == 0);
    foreach (obs_gas[i]) if (obs_gas[i] != i) ok = 0;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL t2_gascon_seq: got %0d gascon/%0d mix entries, required 12/0",
                           obs_gas.size(), obs_mix.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    fill_dv(0);
    dv[6] = 1'b0; dv[7] = 1'b0; dv[8] = 1'b0;
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    checks++;
    if (r_lat != 26) begin failures++; $display("FAIL t3_latency: got %0d, required 26", r_lat); end
    ok = (obs_stall.size() == 3);
    foreach (obs_stall[i]) if (obs_stall[i] != 5) ok = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL t3_stall_hold: got %0d stall cycles, required 3 at mix_rnd 5", obs_stall.size()); end
    checks++;
    if (r_enac_bad != 0) begin failures++; $display("FAIL t3_ena_c: got %0d bad cycles, required 0", r_enac_bad); end
  endtask

  task automatic test_back_to_back();
    fill_dv(0);
    run_job(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    checks++;
    if (r_lat != 9) begin failures++; $display("FAIL t4_latency: got %0d, required 9", r_lat); end
    checks++;
    if (r_rdy_bad != 0 || r_done_rdy != 0) begin
      failures++; $display("FAIL t4_start_rdy_busy: got %0d/%0d, required 0/0", r_rdy_bad, r_done_rdy);
    end
    checks++;
    if (r_post_done != 0) begin failures++; $display("FAIL t4_single_done: got %0d, required 0", r_post_done); end
    checks++;
    if (r_post_rdy != 1 || r_post_busy != 1) begin
      failures++; $display("FAIL t4_reaccept: got rdy=%0d busy=%0d, required 1/1", r_post_rdy, r_post_busy);
    end
  endtask

  task automatic test_mid_reset();
    fill_dv(0);
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 1, 3);
    checks++;
    if (r_int_hit != 1) begin failures++; $display("FAIL t5_reached: got %0d, required 1", r_int_hit); end
    checks++;
    if (r_after !== IDLE_OUTS) begin failures++; $display("FAIL t5_outs: got %h, required %h", r_after, IDLE_OUTS); end
    checks++;
    if (r_post_done != 0) begin failures++; $display("FAIL t5_no_done: got %0d, required 0", r_post_done); end
  endtask

`ifdef DRYGASCON_ABORT_EN
  task automatic test_abort();
    fill_dv(0);
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 2, 7);
    checks++;
    if (r_int_hit != 1 || r_int_out != 1) begin
      failures++; $display("FAIL t6_aborted: got hit=%0d aborted=%0d, required 1/1", r_int_hit, r_int_out);
    end
    checks++;
    if (r_int_en != 0) begin failures++; $display("FAIL t6_enables: got %0d, required 0", r_int_en); end
    checks++;
    if (r_after !== IDLE_OUTS || r_after_ab != 0) begin
      failures++; $display("FAIL t6_idle: got %h/%0d, required %h/0", r_after, r_after_ab, IDLE_OUTS);
    end
    checks++;
    if (r_post_done != 0) begin failures++; $display("FAIL t6_no_done: got %0d, required 0", r_post_done); end
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    checks++;
    if (r_lat != 23) begin failures++; $display("FAIL t6_next_job: got %0d, required 23", r_lat); end
  endtask
`endif

  task automatic test_random();
    bit mix, init, clr, ok;
    int stalls, exp_lat;
    for (int j = 0; j < 8; j++) begin
      mix  = 1'($urandom_range(0, 1));
      init = 1'($urandom_range(0, 1));
      clr  = 1'($urandom_range(0, 1));
      fill_dv(1);
      exp_lat = model_lat(mix, init, stalls);
      run_job(mix, init, clr, 1'b0, 0, 0);
      checks++;
      if (r_lat != exp_lat) begin
        failures++; $display("FAIL rand%0d_latency: got %0d, required %0d", j, r_lat, exp_lat);
      end
      checks++;
      if (r_ena_c != (mix ? 14 : 0) + (init ? 12 : 8) || r_ena_r != (init ? 12 : 8)) begin
        failures++; $display("FAIL rand%0d_enables: got ena_c=%0d ena_r=%0d, required %0d/%0d",
                             j, r_ena_c, r_ena_r, (mix ? 14 : 0) + (init ? 12 : 8), (init ? 12 : 8));
      end
      ok = (obs_mix.size() == (mix ? 14 : 0)) && (obs_gas.size() == (init ? 12 : 8));
      foreach (obs_mix[i]) if (obs_mix[i] != i) ok = 0;
      foreach (obs_gas[i]) if (obs_gas[i] != i) ok = 0;
      checks++;
      if (!ok) begin
        failures++; $display("FAIL rand%0d_round_seq: got %0d mix/%0d gascon indices, out of order or wrong count",
                             j, obs_mix.size(), obs_gas.size());
      end
      checks++;
      if (obs_stall.size() != stalls || r_enac_bad != 0) begin
        failures++; $display("FAIL rand%0d_stalls: got %0d stalls (%0d bad ena_c), required %0d (0)",
                             j, obs_stall.size(), r_enac_bad, stalls);
      end
      checks++;
      if (r_rst_r_acc != int'(clr) || r_rdy_bad != 0) begin
        failures++; $display("FAIL rand%0d_accept: got rst_r=%0d rdy_bad=%0d, required %0d/0",
                             j, r_rst_r_acc, r_rdy_bad, clr);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.init_mode = 1'b0; bus.mix_en = 1'b0;
    bus.clr_r = 1'b0; bus.din_valid = 1'b0;
`ifdef DRYGASCON_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_mix_normal();
    test_init_clr();
    test_stall();
    test_back_to_back();
    test_mid_reset();
`ifdef DRYGASCON_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
